// File: rtl/bfm_apb_arbiter.sv
// Round-robin arbiter sharing one APB3 master port among NREQ requesters.
// Each grant runs one full SETUP/ACCESS transfer with a 16-way PSEL decode
// on PADDR[27:24] and a wait-state watchdog that aborts hung transfers.
//
// Requester handshake: a requester raises REQ[i] with REQ_ADDR/REQ_WRITE/
// REQ_WDATA valid and holds them until it sees DONE[i]. The request fields are
// sampled once, on the edge that issues the grant, and never re-read. DONE[i]
// is a single-cycle pulse carrying RDATA/SLVERR; REQ is ignored during the
// cycle after DONE, so the requester may drop REQ on seeing DONE.
module bfm_apb_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [32*NREQ-1:0]   REQ_ADDR,
    input  logic [NREQ-1:0]      REQ_WRITE,
    input  logic [32*NREQ-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      DONE,
    output logic [31:0]          RDATA,
    output logic                 SLVERR,
    output logic                 TOUT,
    output logic                 BUSY,
    output logic [15:0]          PSEL,
    output logic [31:0]          PADDR,
    output logic                 PWRITE,
    output logic                 PENABLE,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);
    localparam logic [CW-1:0] TO_V    = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETUP    = 2'd1,
        S_ACCESS   = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [CW-1:0]     wd_cnt_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic [31:0]       rdata_q;
    logic              slverr_q;
    logic              tout_q;
    logic              busy_q;
    logic [15:0]       psel_q;
    logic [31:0]       paddr_q;
    logic              pwrite_q;
    logic              penable_q;
    logic [31:0]       pwdata_q;

    // Arbitration result for the current IDLE cycle
    logic              pick_valid_d;
    logic [PW-1:0]     pick_idx_d;
    logic [PW-1:0]     cand_d;
    logic [NREQ-1:0]   pick_gnt_d;
    logic [31:0]       pick_addr_d;
    logic              pick_write_d;
    logic [31:0]       pick_wdata_d;

    // ACCESS-phase exit decision and completion payload
    logic              wd_hit_d;
    logic              exit_d;
    logic [31:0]       fin_rdata_d;
    logic              fin_slverr_d;
    logic              fin_tout_d;

    // Round-robin search: first set REQ bit starting just above the pointer, with wrap
    always_comb begin
        pick_valid_d = 1'b0;
        pick_idx_d   = '0;
        cand_d       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (int'(ptr_q) + k >= NREQ) begin
                cand_d = PW'(int'(ptr_q) + k - NREQ);
            end else begin
                cand_d = PW'(int'(ptr_q) + k);
            end
            if (!pick_valid_d && REQ[cand_d]) begin
                pick_valid_d = 1'b1;
                pick_idx_d   = cand_d;
            end
        end
    end

    // Mux the winning requester's command fields
    always_comb begin
        pick_gnt_d   = '0;
        pick_addr_d  = '0;
        pick_write_d = 1'b0;
        pick_wdata_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx_d == PW'(i)) begin
                pick_gnt_d[i] = 1'b1;
                pick_addr_d   = REQ_ADDR[32*i +: 32];
                pick_write_d  = REQ_WRITE[i];
                pick_wdata_d  = REQ_WDATA[32*i +: 32];
            end
        end
    end

    // Watchdog fires on the ACCESS cycle that brings the stall count up to TIMEOUT;
    // a real PREADY in that same cycle still wins.
    always_comb begin
        wd_hit_d     = (TIMEOUT != 0) && (wd_cnt_q + CW'(1) == TO_V);
        exit_d       = PREADY || wd_hit_d;
        fin_rdata_d  = PREADY ? PRDATA  : 32'h0;
        fin_slverr_d = PREADY ? PSLVERR : 1'b1;
        fin_tout_d   = !PREADY;
    end

    // Transfer FSM with all APB and requester-facing outputs registered
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_RST;
            wd_cnt_q  <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            tout_q    <= 1'b0;
            busy_q    <= 1'b0;
            psel_q    <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid_d) begin
                        ptr_q     <= pick_idx_d;
                        gnt_q     <= pick_gnt_d;
                        psel_q    <= 16'(1) << pick_addr_d[27:24];
                        paddr_q   <= pick_addr_d;
                        pwrite_q  <= pick_write_d;
                        pwdata_q  <= pick_wdata_d;
                        penable_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    wd_cnt_q  <= '0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (exit_d) begin
                        rdata_q   <= fin_rdata_d;
                        slverr_q  <= fin_slverr_d;
                        tout_q    <= fin_tout_d;
                        done_q    <= gnt_q;
                        gnt_q     <= '0;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        state_q   <= S_COMPLETE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CW'(1);
                    end
                end
                S_COMPLETE: begin
                    done_q  <= '0;
                    tout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign GNT     = gnt_q;
    assign DONE    = done_q;
    assign RDATA   = rdata_q;
    assign SLVERR  = slverr_q;
    assign TOUT    = tout_q;
    assign BUSY    = busy_q;
    assign PSEL    = psel_q;
    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = penable_q;
    assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_bfm_apb_arbiter.sv
// Directed bench for bfm_apb_arbiter (NREQ=4, TIMEOUT=8).
module tb_bfm_apb_arbiter;

    logic          PCLK;
    logic          PRESET;
    logic [3:0]    REQ;
    logic [127:0]  REQ_ADDR;
    logic [3:0]    REQ_WRITE;
    logic [127:0]  REQ_WDATA;
    logic [3:0]    GNT;
    logic [3:0]    DONE;
    logic [31:0]   RDATA;
    logic          SLVERR;
    logic          TOUT;
    logic          BUSY;
    logic [15:0]   PSEL;
    logic [31:0]   PADDR;
    logic          PWRITE;
    logic          PENABLE;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int n_run;
    int n_fail;

    bfm_apb_arbiter #(.NREQ(4), .TIMEOUT(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA),
        .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .SLVERR(SLVERR), .TOUT(TOUT), .BUSY(BUSY),
        .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Clock
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
        REQ_ADDR[32*i +: 32]  = a;
        REQ_WRITE[i]          = w;
        REQ_WDATA[32*i +: 32] = d;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        REQ    = 4'b1111;
        tick();
        tick();
        n_run++; if (GNT !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %h expected 0", GNT); end
        n_run++; if (DONE !== 4'b0) begin n_fail++; $display("FAIL reset_done: got %h expected 0", DONE); end
        n_run++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        n_run++; if (PSEL !== 16'h0) begin n_fail++; $display("FAIL reset_psel: got %h expected 0", PSEL); end
        n_run++; if ({PWRITE, PENABLE, SLVERR, TOUT} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {PWRITE, PENABLE, SLVERR, TOUT}); end
        n_run++; if ({PADDR, PWDATA, RDATA} !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {PADDR, PWDATA, RDATA}); end
        REQ    = 4'b0000;
        PRESET = 1'b0;
        tick();
    endtask

    task automatic test_read();
        PREADY  = 1'b1;
        PRDATA  = 32'hDEAD_BEEF;
        PSLVERR = 1'b0;
        set_req(0, 32'h0300_0010, 1'b0, 32'h0);
        REQ = 4'b0001;
        tick();
        n_run++; if (GNT !== 4'b0001) begin n_fail++; $display("FAIL read_gnt: got %h expected 1", GNT); end
        n_run++; if (PSEL !== 16'h0008) begin n_fail++; $display("FAIL read_psel_setup: got %h expected 0008", PSEL); end
        n_run++; if (PENABLE !== 1'b0) begin n_fail++; $display("FAIL read_penable_setup: got %b expected 0", PENABLE); end
        n_run++; if (PADDR !== 32'h0300_0010) begin n_fail++; $display("FAIL read_paddr: got %h expected 03000010", PADDR); end
        n_run++; if (PWRITE !== 1'b0) begin n_fail++; $display("FAIL read_pwrite: got %b expected 0", PWRITE); end
        n_run++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b expected 1", BUSY); end
        tick();
        n_run++; if (PSEL !== 16'h0008) begin n_fail++; $display("FAIL read_psel_access: got %h expected 0008", PSEL); end
        n_run++; if (PENABLE !== 1'b1) begin n_fail++; $display("FAIL read_penable_access: got %b expected 1", PENABLE); end
        n_run++; if (DONE !== 4'b0) begin n_fail++; $display("FAIL read_done_early: got %h expected 0", DONE); end
        tick();
        n_run++; if (DONE !== 4'b0001) begin n_fail++; $display("FAIL read_done: got %h expected 1", DONE); end
        n_run++; if (RDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_rdata: got %h expected deadbeef", RDATA); end
        n_run++; if ({SLVERR, TOUT} !== 2'b00) begin n_fail++; $display("FAIL read_status: got %b expected 00", {SLVERR, TOUT}); end
        n_run++; if ({GNT, PSEL, PENABLE} !== 21'h0) begin n_fail++; $display("FAIL read_release: got %h expected 0", {GNT, PSEL, PENABLE}); end
        n_run++; if (PADDR !== 32'h0) begin n_fail++; $display("FAIL read_paddr_zero: got %h expected 0", PADDR); end
        REQ = 4'b0000;
        tick();
        n_run++; if (DONE !== 4'b0) begin n_fail++; $display("FAIL read_done_pulse: got %h expected 0", DONE); end
        n_run++; if (RDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_rdata_hold: got %h expected deadbeef", RDATA); end
        n_run++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL read_busy_clear: got %b expected 0", BUSY); end
    endtask

    // Back-to-back round robin: 1111 held gives 0,1,2,3; then 0101 gives 0,2
    task automatic test_back_to_back();
        int ord[6];
        int waited;
        logic [3:0] exp_oh;
        logic [31:0] exp_addr;
        ord = '{0, 1, 2, 3, 0, 2};
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        PREADY = 1'b1;
        PRDATA = 32'h0000_1111;
        for (int i = 0; i < 4; i++) begin
            set_req(i, (32'(i + 1) << 24) | 32'(4 * i), 1'b1, 32'hA000_0000 + 32'(i));
        end
        REQ = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            exp_oh   = 4'(1 << ord[n]);
            exp_addr = (32'(ord[n] + 1) << 24) | 32'(4 * ord[n]);
            waited   = 0;
            while (GNT == 4'b0 && waited < 12) begin
                tick();
                waited++;
            end
            n_run++; if (GNT !== exp_oh) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %h expected %h", n, GNT, exp_oh); end
            n_run++; if (PADDR !== exp_addr) begin n_fail++; $display("FAIL b2b_paddr[%0d]: got %h expected %h", n, PADDR, exp_addr); end
            if (n > 0) begin
                n_run++; if (waited != 2) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 2", n, waited); end
            end
            waited = 0;
            while (DONE == 4'b0 && waited < 12) begin
                tick();
                waited++;
            end
            n_run++; if (DONE !== exp_oh) begin n_fail++; $display("FAIL b2b_done[%0d]: got %h expected %h", n, DONE, exp_oh); end
            if (n == 3) REQ = 4'b0101;
            if (n == 5) REQ = 4'b0000;
        end
        tick();
        tick();
    endtask

    task automatic test_wait_states();
        int pen;
        int unstable;
        pen      = 0;
        unstable = 0;
        set_req(1, 32'h0A00_0004, 1'b1, 32'h1234_5678);
        PREADY = 1'b0;
        PRDATA = 32'h5555_AAAA;
        REQ    = 4'b0010;
        tick();
        n_run++; if (GNT !== 4'b0010) begin n_fail++; $display("FAIL ws_gnt: got %h expected 2", GNT); end
        n_run++; if (PSEL !== 16'h0400) begin n_fail++; $display("FAIL ws_psel: got %h expected 0400", PSEL); end
        n_run++; if (PWRITE !== 1'b1) begin n_fail++; $display("FAIL ws_pwrite: got %b expected 1", PWRITE); end
        tick();
        for (int i = 0; i < 6; i++) begin
            if (PENABLE === 1'b1) pen++;
            if (PADDR !== 32'h0A00_0004 || PWDATA !== 32'h1234_5678 || PSEL !== 16'h0400 ||
                PWRITE !== 1'b1 || DONE !== 4'b0) unstable++;
            if (i == 5) PREADY = 1'b1;
            tick();
        end
        n_run++; if (pen != 6) begin n_fail++; $display("FAIL ws_penable_cycles: got %0d expected 6", pen); end
        n_run++; if (unstable != 0) begin n_fail++; $display("FAIL ws_stable: got %0d unstable cycles expected 0", unstable); end
        n_run++; if (DONE !== 4'b0010) begin n_fail++; $display("FAIL ws_done: got %h expected 2", DONE); end
        n_run++; if (RDATA !== 32'h5555_AAAA) begin n_fail++; $display("FAIL ws_rdata: got %h expected 5555aaaa", RDATA); end
        n_run++; if ({PENABLE, TOUT, SLVERR} !== 3'b000) begin n_fail++; $display("FAIL ws_flags: got %b expected 000", {PENABLE, TOUT, SLVERR}); end
        n_run++; if (PWDATA !== 32'h0) begin n_fail++; $display("FAIL ws_pwdata_zero: got %h expected 0", PWDATA); end
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_watchdog();
        int pen;
        int waited;
        pen    = 0;
        waited = 0;
        set_req(2, 32'h0200_0020, 1'b0, 32'h0);
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_FFFF;
        REQ    = 4'b0100;
        tick();
        n_run++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL wd_gnt: got %h expected 4", GNT); end
        while (DONE == 4'b0 && waited < 30) begin
            if (PENABLE === 1'b1) pen++;
            tick();
            waited++;
        end
        n_run++; if (pen != 8) begin n_fail++; $display("FAIL wd_access_cycles: got %0d expected 8", pen); end
        n_run++; if (DONE !== 4'b0100) begin n_fail++; $display("FAIL wd_done: got %h expected 4", DONE); end
        n_run++; if (TOUT !== 1'b1) begin n_fail++; $display("FAIL wd_tout: got %b expected 1", TOUT); end
        n_run++; if (SLVERR !== 1'b1) begin n_fail++; $display("FAIL wd_slverr: got %b expected 1", SLVERR); end
        n_run++; if (RDATA !== 32'h0) begin n_fail++; $display("FAIL wd_rdata: got %h expected 0", RDATA); end
        n_run++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL wd_busy_complete: got %b expected 1", BUSY); end
        REQ = 4'b0000;
        tick();
        n_run++; if ({TOUT, DONE} !== 5'b0) begin n_fail++; $display("FAIL wd_pulse: got %b expected 0", {TOUT, DONE}); end
        n_run++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL wd_busy_clear: got %b expected 0", BUSY); end
        n_run++; if (SLVERR !== 1'b1) begin n_fail++; $display("FAIL wd_slverr_hold: got %b expected 1", SLVERR); end
        PREADY = 1'b1;
    endtask

    // Slave error on a read, with REQ dropped mid-transfer (must still complete)
    task automatic test_slverr();
        set_req(3, 32'h0F00_0008, 1'b0, 32'h0);
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'hCAFE_0001;
        REQ     = 4'b1000;
        tick();
        n_run++; if (GNT !== 4'b1000) begin n_fail++; $display("FAIL se_gnt: got %h expected 8", GNT); end
        n_run++; if (PSEL !== 16'h8000) begin n_fail++; $display("FAIL se_psel: got %h expected 8000", PSEL); end
        REQ = 4'b0000;
        tick();
        tick();
        n_run++; if (DONE !== 4'b1000) begin n_fail++; $display("FAIL se_done: got %h expected 8", DONE); end
        n_run++; if (SLVERR !== 1'b1) begin n_fail++; $display("FAIL se_slverr: got %b expected 1", SLVERR); end
        n_run++; if (RDATA !== 32'hCAFE_0001) begin n_fail++; $display("FAIL se_rdata: got %h expected cafe0001", RDATA); end
        n_run++; if (TOUT !== 1'b0) begin n_fail++; $display("FAIL se_tout: got %b expected 0", TOUT); end
        PSLVERR = 1'b0;
        tick();
        n_run++; if ({DONE, GNT, BUSY} !== 9'b0) begin n_fail++; $display("FAIL se_idle: got %b expected 0", {DONE, GNT, BUSY}); end
    endtask

    task automatic test_reset_mid();
        int waited;
        set_req(2, 32'h0500_0000, 1'b0, 32'h0);
        PREADY = 1'b0;
        PRDATA = 32'h7777_7777;
        REQ    = 4'b0100;
        tick();
        n_run++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL rm_gnt_before: got %h expected 4", GNT); end
        tick();
        tick();
        set_req(1, 32'h0600_0000, 1'b0, 32'h0);
        set_req(3, 32'h0700_0000, 1'b0, 32'h0);
        PRESET = 1'b1;
        REQ    = 4'b1010;
        tick();
        n_run++; if ({GNT, DONE, BUSY, PENABLE, PWRITE, TOUT, SLVERR} !== 13'b0) begin n_fail++; $display("FAIL rm_ctrl: got %b expected 0", {GNT, DONE, BUSY, PENABLE, PWRITE, TOUT, SLVERR}); end
        n_run++; if ({PSEL, PADDR, RDATA} !== 80'h0) begin n_fail++; $display("FAIL rm_data: got %h expected 0", {PSEL, PADDR, RDATA}); end
        PRESET = 1'b0;
        PREADY = 1'b1;
        tick();
        n_run++; if (GNT !== 4'b0010) begin n_fail++; $display("FAIL rm_first_grant: got %h expected 2", GNT); end
        n_run++; if (DONE !== 4'b0) begin n_fail++; $display("FAIL rm_no_done: got %h expected 0", DONE); end
        waited = 0;
        while (DONE == 4'b0 && waited < 12) begin
            tick();
            waited++;
        end
        n_run++; if (DONE !== 4'b0010) begin n_fail++; $display("FAIL rm_done: got %h expected 2", DONE); end
        n_run++; if (RDATA !== 32'h7777_7777) begin n_fail++; $display("FAIL rm_rdata: got %h expected 77777777", RDATA); end
        REQ = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        n_run     = 0;
        n_fail    = 0;
        PRESET    = 1'b1;
        REQ       = 4'b0;
        REQ_ADDR  = '0;
        REQ_WRITE = 4'b0;
        REQ_WDATA = '0;
        PRDATA    = 32'h0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        test_reset();
        test_read();
        test_back_to_back();
        test_wait_states();
        test_watchdog();
        test_slverr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
